// File: rtl/ram_2bit_div_reader.sv
// ram_2bit_div_reader: bursts PACK narrow RAM entries per output word, LSB-first, with valid/ready output.
// Optional read-and-clear write port enabled by macro RAM_READER_CLEAR_EN.
module ram_2bit_div_reader #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 7,
  parameter int PACK       = 4
) (
  input  logic                         clk,
  input  logic                         async_clear,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic [ADDR_WIDTH-1:0]        word_cnt,
  output logic [ADDR_WIDTH-1:0]        read_addr,
  input  logic [DATA_WIDTH-1:0]        q,
  output logic [DATA_WIDTH*PACK-1:0]   out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
`ifdef RAM_READER_CLEAR_EN
  output logic                         clr_we,
  output logic [ADDR_WIDTH-1:0]        clr_addr,
  output logic [DATA_WIDTH-1:0]        clr_data,
`endif
  output logic                         done
);
  localparam int PW = $clog2(PACK + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(PACK);
  localparam logic [PW-1:0] PH_ADDR_LAST = PW'(PACK - 1);
  typedef enum logic [1:0] {IDLE, READ, HOLD, FIN} state_t;
  state_t                       state_q, state_d;
  logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]                ph_q, ph_d;
  logic [DATA_WIDTH*PACK-1:0]   data_q, data_d;
  // READ spans PACK+1 cycles: ph 0..PACK-1 issue addresses, ph 1..PACK capture q one cycle later
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = (word_cnt == '0) ? FIN : READ;
        addr_d  = (word_cnt == '0) ? addr_q : base_addr;
        cnt_d   = word_cnt;
        ph_d    = '0;
      end
      READ: begin
        data_d  = (ph_q != '0) ? {q, data_q[DATA_WIDTH*PACK-1:DATA_WIDTH]} : data_q;
        addr_d  = (ph_q < PH_ADDR_LAST) ? addr_q + ADDR_WIDTH'(1) : addr_q;
        ph_d    = (ph_q == PH_LAST) ? '0 : ph_q + PW'(1);
        state_d = (ph_q == PH_LAST) ? HOLD : READ;
      end
      HOLD: if (out_ready) begin
        cnt_d   = cnt_q - ADDR_WIDTH'(1);
        ph_d    = '0;
        state_d = (cnt_q == ADDR_WIDTH'(1)) ? FIN : READ;
        addr_d  = (cnt_q == ADDR_WIDTH'(1)) ? addr_q : addr_q + ADDR_WIDTH'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge async_clear) begin
    if (async_clear) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      ph_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      data_q  <= data_d;
    end
  end
  assign read_addr = addr_q;
  assign out_data  = data_q;
  assign out_valid = state_q == HOLD;
  assign busy      = state_q != IDLE;
  assign done      = state_q == FIN;
`ifdef RAM_READER_CLEAR_EN
  // The write lands in the same cycle the entry is on q, addressed by the previous read_addr
  logic                  clr_we_q;
  logic [ADDR_WIDTH-1:0] clr_addr_q;
  always_ff @(posedge clk or posedge async_clear) begin
    if (async_clear) begin
      clr_we_q   <= 1'b0;
      clr_addr_q <= '0;
    end else begin
      clr_we_q   <= state_q == READ && ph_q < PH_LAST;
      clr_addr_q <= (state_q == READ && ph_q < PH_LAST) ? addr_q : clr_addr_q;
    end
  end
  assign clr_we   = clr_we_q;
  assign clr_addr = clr_addr_q;
  assign clr_data = '0;
`endif
endmodule

// File: tb/tb_ram_2bit_div_reader.sv
// tb_ram_2bit_div_reader: directed checks of burst timing, packing, backpressure, wrap and async clear.
module tb_ram_2bit_div_reader;
  logic       clk = 1'b0;
  logic       async_clear = 1'b1;
  logic       start = 1'b0;
  logic [6:0] base_addr = '0;
  logic [6:0] word_cnt = '0;
  logic [6:0] read_addr;
  logic [1:0] q = '0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       busy;
  logic       done;
  logic [1:0] mem [128];
  int         checks = 0;
  int         errors = 0;
`ifdef RAM_READER_CLEAR_EN
  logic       clr_we;
  logic [6:0] clr_addr;
  logic [1:0] clr_data;
`endif

  ram_2bit_div_reader dut (
    .clk(clk), .async_clear(async_clear), .start(start), .base_addr(base_addr),
    .word_cnt(word_cnt), .read_addr(read_addr), .q(q), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
`ifdef RAM_READER_CLEAR_EN
    .clr_we(clr_we), .clr_addr(clr_addr), .clr_data(clr_data),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    q <= mem[read_addr];
`ifdef RAM_READER_CLEAR_EN
    if (clr_we) mem[clr_addr] <= clr_data;
`endif
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_burst(input logic [6:0] b, input logic [6:0] n);
    start = 1'b1;
    base_addr = b;
    word_cnt = n;
    step();
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 2'(i % 4);
    repeat (2) @(negedge clk);
    chk("rst_addr", read_addr, 0);
    chk("rst_data", out_data, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    async_clear = 1'b0;

    // two-word burst from 0 with out_ready held high
    start_burst(7'd0, 7'd2);
    chk("b1_addr_t1", read_addr, 0);
    chk("b1_busy", busy, 1);
    for (int k = 1; k < 4; k++) begin
      step();
      chk("b1_addr_step", read_addr, k);
    end
    step();
    chk("b1_valid_t5", out_valid, 0);
    step();
    chk("b1_valid_t6", out_valid, 1);
    chk("b1_word0", out_data, 8'hE4);
    step();
    chk("b1_valid_t7", out_valid, 0);
    chk("b1_addr_t7", read_addr, 4);
    repeat (5) step();
    chk("b1_valid_w1", out_valid, 1);
    chk("b1_word1", out_data, 8'hE4);
    step();
    chk("b1_done", done, 1);
    step();
    chk("b1_done_off", done, 0);
    chk("b1_idle", busy, 0);

    // address wrap plus ten cycles of backpressure
    mem[126] = 2'd3; mem[127] = 2'd0; mem[0] = 2'd1; mem[1] = 2'd2;
    out_ready = 1'b0;
    start_burst(7'd126, 7'd1);
    chk("wr_addr0", read_addr, 126);
    step(); chk("wr_addr1", read_addr, 127);
    step(); chk("wr_addr2", read_addr, 0);
    step(); chk("wr_addr3", read_addr, 1);
    repeat (2) step();
    chk("wr_valid", out_valid, 1);
    chk("wr_word", out_data, 8'h93);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("bp_data", out_data, 8'h93);
      chk("bp_valid", out_valid, 1);
      chk("bp_addr", read_addr, 1);
    end
    out_ready = 1'b1;
    step();
    chk("bp_valid_off", out_valid, 0);
    chk("bp_done", done, 1);
    chk("bp_addr_hold", read_addr, 1);
    step();
    chk("bp_idle", busy, 0);

    // empty burst
    start_burst(7'd50, 7'd0);
    chk("z_done", done, 1);
    chk("z_valid", out_valid, 0);
    chk("z_addr_hold", read_addr, 1);
    step();
    chk("z_done_off", done, 0);
    chk("z_idle", busy, 0);
    chk("z_valid2", out_valid, 0);

    // start while busy is ignored
    start_burst(7'd8, 7'd1);
    step();
    start = 1'b1; base_addr = 7'd40; word_cnt = 7'd5;
    step();
    start = 1'b0;
    chk("ig_addr_t3", read_addr, 10);
    step();
    chk("ig_addr_t4", read_addr, 11);
    repeat (2) step();
    chk("ig_valid", out_valid, 1);
    chk("ig_word", out_data, 8'hE4);
    step();
    chk("ig_done", done, 1);
    step();
    chk("ig_idle", busy, 0);
    chk("ig_done_off", done, 0);

    // async clear in cycle T+3
    start_burst(7'd5, 7'd2);
    repeat (2) step();
    chk("ac_busy_pre", busy, 1);
    #2 async_clear = 1'b1;
    #1;
    chk("ac_addr", read_addr, 0);
    chk("ac_data", out_data, 0);
    chk("ac_valid", out_valid, 0);
    chk("ac_busy", busy, 0);
    chk("ac_done", done, 0);
    @(negedge clk);
    async_clear = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("ac_no_word", out_valid, 0);
    end
    chk("ac_idle", busy, 0);
    start_burst(7'd12, 7'd1);
    chk("ac_new_addr", read_addr, 12);
    repeat (5) step();
    chk("ac_new_valid", out_valid, 1);
    chk("ac_new_word", out_data, 8'hE4);
    step();
    chk("ac_new_done", done, 1);
    step();
`ifdef RAM_READER_CLEAR_EN
    start_burst(7'd12, 7'd1);
    repeat (5) step();
    chk("clr_reread_valid", out_valid, 1);
    chk("clr_reread_word", out_data, 8'h00);
    repeat (2) step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
